// File: rtl/debounce_timer_arbiter_pkg.sv
// Shared definitions for the debounce timer arbiter: FSM state encoding and
// an elaboration-time log2 helper for the channel index width.
package debounce_timer_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/debounce_timer_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit at or above
// rr_ptr, wrapping around to bit 0.
module debounce_timer_arbiter_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic              any_req,
  output logic [IDX_W-1:0]  sel
);

  int               j;
  logic [IDX_W-1:0] jj;

  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    j       = 0;
    jj      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      jj = IDX_W'(j);
      if (!any_req && req[jj]) begin
        any_req = 1'b1;
        sel     = jj;
      end
    end
  end

endmodule

// File: rtl/debounce_timer_arbiter.sv
// One debounce interval counter shared round-robin between NUM_CH channel
// FSMs; the granted channel gets a one-cycle timer_done after DEBOUNCE_CYCLES.
module debounce_timer_arbiter
  import debounce_timer_arbiter_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int IDX_W           = clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] timer_req,
  output logic [NUM_CH-1:0] timer_done,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  active_ch,
  output logic              busy
);

  if (NUM_CH < 2 || DEBOUNCE_CYCLES < 2 ||
      (longint'(DEBOUNCE_CYCLES) - 1) >= (longint'(1) << CNT_W)) begin : g_bad_params
    $error("debounce_timer_arbiter: illegal NUM_CH/DEBOUNCE_CYCLES/CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [IDX_W-1:0]    rr_ptr, rr_ptr_n, active_n, sel;
  logic [NUM_CH-1:0]   grant_n, done_n;
  logic                busy_n, any_req;

  debounce_timer_arbiter_rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req     (timer_req),
    .rr_ptr  (rr_ptr),
    .any_req (any_req),
    .sel     (sel)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rr_ptr_n = rr_ptr;
    grant_n  = grant;
    active_n = active_ch;
    busy_n   = busy;
    done_n   = '0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_n  = ST_COUNT;
          grant_n  = NUM_CH'(1) << sel;
          active_n = sel;
          cnt_n    = '0;
          busy_n   = 1'b1;
        end
      end
      ST_COUNT: begin
        // A dropped request aborts without touching rr_ptr, so the channel keeps its turn.
        if (!timer_req[active_ch]) begin
          state_n  = ST_IDLE;
          grant_n  = '0;
          active_n = '0;
          busy_n   = 1'b0;
          cnt_n    = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_DONE;
          done_n  = grant;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        state_n  = ST_IDLE;
        grant_n  = '0;
        active_n = '0;
        busy_n   = 1'b0;
        cnt_n    = '0;
        rr_ptr_n = (active_ch == IDX_W'(NUM_CH - 1)) ? '0 : active_ch + 1'b1;
      end
      default: begin
        state_n  = ST_IDLE;
        grant_n  = '0;
        active_n = '0;
        busy_n   = 1'b0;
        cnt_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rr_ptr     <= '0;
      grant      <= '0;
      active_ch  <= '0;
      busy       <= 1'b0;
      timer_done <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rr_ptr     <= rr_ptr_n;
      grant      <= grant_n;
      active_ch  <= active_n;
      busy       <= busy_n;
      timer_done <= done_n;
    end
  end

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Bench for debounce_timer_arbiter (NUM_CH=4, DEBOUNCE_CYCLES=8): per-cycle
// vector table through an expected-value queue, plus an async-reset sequence.
module tb_debounce_timer_arbiter;

  localparam int NUM_CH = 4;
  localparam int DEB    = 8;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = 2;
  localparam int OW     = 2 * NUM_CH + IDX_W + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] timer_req = '0;
  logic [NUM_CH-1:0] timer_done;
  logic [NUM_CH-1:0] grant;
  logic [IDX_W-1:0]  active_ch;
  logic              busy;

  // clock / reset
  always #5 clk = ~clk;

  debounce_timer_arbiter #(
    .NUM_CH          (NUM_CH),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .timer_req  (timer_req),
    .timer_done (timer_done),
    .grant      (grant),
    .active_ch  (active_ch),
    .busy       (busy)
  );

  // One record per clock edge: inputs driven before the edge, outputs expected after it.
  typedef struct {
    logic              rst_n;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] done;
    logic [IDX_W-1:0]  act;
    logic              busy;
    int                tag;
  } vec_t;

  vec_t           vecs[$];
  logic [OW-1:0]  exp_q[$];
  int             n_checks = 0;
  int             n_fail   = 0;
  int             cur_tag  = 0;
  string          tag_name [0:6] = '{"single_ch2", "pair_ch0_ch2", "all_four_rr",
                                     "abort_ch1", "async_reset", "drop_in_done", "misc"};

  // scoreboard
  task automatic check_outputs(input string name);
    logic [OW-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    e = exp_q.pop_front();
    if ({grant, timer_done, active_ch, busy} !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got grant=%b done=%b active_ch=%0d busy=%b, expected grant=%b done=%b active_ch=%0d busy=%b",
               name, $time, grant, timer_done, active_ch, busy, e[10:7], e[6:3], e[2:1], e[0]);
    end
    n_checks++;
    if (((grant & (grant - 1'b1)) != '0) || ((timer_done & ~grant) != '0)) begin
      n_fail++;
      $display("FAIL %s_invariant @%0t: grant=%b done=%b, expected one-hot/zero grant covering done",
               name, $time, grant, timer_done);
    end
  endtask

  // driver
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst_n     = v.rst_n;
    timer_req = v.req;
    exp_q.push_back({v.grant, v.done, v.act, v.busy});
    @(posedge clk);
    #1;
    check_outputs(tag_name[v.tag]);
  endtask

  function automatic vec_t mk(input logic r, input logic [NUM_CH-1:0] req,
                              input logic [NUM_CH-1:0] g, input logic [NUM_CH-1:0] d,
                              input logic [IDX_W-1:0] a, input logic b);
    vec_t v;
    v.rst_n = r; v.req = req; v.grant = g; v.done = d; v.act = a; v.busy = b; v.tag = cur_tag;
    return v;
  endfunction

  task automatic add_reset();
    vecs.push_back(mk(1'b0, '0, '0, '0, '0, 1'b0));
  endtask

  task automatic add_idle(input logic [NUM_CH-1:0] req);
    vecs.push_back(mk(1'b1, req, '0, '0, '0, 1'b0));
  endtask

  task automatic add_count(input int ch, input logic [NUM_CH-1:0] req, input int n);
    logic [NUM_CH-1:0] g;
    g = NUM_CH'(1) << ch;
    for (int i = 0; i < n; i++) vecs.push_back(mk(1'b1, req, g, '0, IDX_W'(ch), 1'b1));
  endtask

  // Full grant: DEB counting edges, the done cycle, then the edge back to idle.
  task automatic add_service(input int ch, input logic [NUM_CH-1:0] req_hold,
                             input logic [NUM_CH-1:0] req_last);
    logic [NUM_CH-1:0] g;
    g = NUM_CH'(1) << ch;
    add_count(ch, req_hold, DEB);
    vecs.push_back(mk(1'b1, req_hold, g, g, IDX_W'(ch), 1'b1));
    add_idle(req_last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single channel: grant from edge 0, done after edge 8, idle after edge 9.
    cur_tag = 0;
    add_reset();
    add_service(2, 4'b0100, 4'b0000);
    add_idle(4'b0000);

    // Two simultaneous requests: ch0 first, ch2 granted at edge 10.
    cur_tag = 1;
    add_reset();
    add_service(0, 4'b0101, 4'b0101);
    add_service(2, 4'b0101, 4'b0000);

    // All requesting: order 0,1,2,3,0 with 10-cycle spacing.
    cur_tag = 2;
    add_reset();
    for (int k = 0; k < 4; k++) add_service(k, 4'b1111, 4'b1111);
    add_service(0, 4'b1111, 4'b0000);

    // Abort ch1 at cnt=3; rr_ptr unchanged so ch1 wins again over ch3,
    // then a second abort lets the pending ch3 in on the following edge.
    cur_tag = 3;
    add_reset();
    add_count(1, 4'b1010, 4);
    add_idle(4'b1000);
    add_count(1, 4'b1010, 4);
    add_idle(4'b1000);
    add_service(3, 4'b1000, 4'b0000);

    // Request dropped while done is high: pulse still one cycle, next grant normal.
    cur_tag = 5;
    add_reset();
    add_service(0, 4'b0001, 4'b0000);
    add_service(1, 4'b0011, 4'b0000);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Async reset at cnt=5: outputs clear without waiting for an edge, no done follows.
    cur_tag = 4;
    apply(mk(1'b0, '0, '0, '0, '0, 1'b0));
    for (int i = 0; i < 6; i++) apply(mk(1'b1, 4'b0010, 4'b0010, '0, 2'd1, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back('0);
    check_outputs("async_reset_immediate");
    apply(mk(1'b0, 4'b0010, '0, '0, '0, 1'b0));
    apply(mk(1'b0, 4'b0010, '0, '0, '0, 1'b0));
    for (int i = 0; i < DEB; i++) apply(mk(1'b1, 4'b0010, 4'b0010, '0, 2'd1, 1'b1));
    apply(mk(1'b1, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1));
    apply(mk(1'b1, 4'b0000, '0, '0, '0, 1'b0));
    apply(mk(1'b1, 4'b0000, '0, '0, '0, 1'b0));

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
